// File: rtl/uop_pkg.sv
// Shared types and helpers for the uop_block datapath and its issue controller.
//
// Contents:
//   UOP_W / UOP_SHAMT_W : default datapath width and matching shift-amount width
//   uop_shamt_t         : shift-amount type for the default width
//   uop_lat()           : block latency = number of register stages enabled in
//                         ff_mask[len-1:0] (popcount). A parent builds the
//                         issue controller with LAT = uop_lat(FF_MASK, LEN).
package uop_pkg;

  localparam int UOP_W       = 32;
  localparam int UOP_SHAMT_W = $clog2(UOP_W);

  typedef logic [UOP_SHAMT_W-1:0] uop_shamt_t;

  function automatic int uop_lat(logic [31:0] ff_mask, int len);
    int n;
    n = 0;
    for (int i = 0; i < 32; i++) begin
      if ((i < len) && ff_mask[i]) begin
        n++;
      end
    end
    return n;
  endfunction

endpackage

// File: rtl/uop_result_fifo.sv
// Result buffer for the issue controller: synchronous FIFO with a registered
// head (first-word-fall-through) and a registered occupancy count.
//
// Parameters:
//   DW     word width (result, plus tag when tags are enabled)
//   DEPTH  number of entries, 2..16
// Ports:
//   clk         clock
//   rst_n       synchronous reset, active low
//   push        write push_data this cycle
//   push_data   word to write
//   pop         consume the head this cycle (only legal while head_valid)
//   head_valid  registered: head_data holds a valid word
//   head_data   registered oldest word; stable until popped
//   count       registered number of stored words (head included)
module uop_result_fifo #(
  parameter int  DW    = 32,
  parameter int  DEPTH = 4,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [DW-1:0]    push_data,
  input  logic             pop,
  output logic             head_valid,
  output logic [DW-1:0]    head_data,
  output logic [CNT_W-1:0] count
);

  localparam int PW = $clog2(DEPTH);

  // Backing store behind the head register; read is registered into the head.
  logic [DW-1:0]    mem [DEPTH];
  logic [PW-1:0]    wr_ptr_reg;
  logic [PW-1:0]    rd_ptr_reg;
  logic [CNT_W-1:0] mem_count_reg;
  logic [CNT_W-1:0] count_reg;
  logic             head_valid_reg;
  logic [DW-1:0]    head_data_reg;

  logic head_take;
  logic load_mem;
  logic load_push;
  logic mem_wr;

  // The head slot is refilled whenever it is empty or being popped. The store
  // has priority (it holds older words); a push bypasses straight into the
  // head only when the store is empty, which keeps write-to-visible at one edge.
  assign head_take = !head_valid_reg || pop;
  assign load_mem  = head_take && (mem_count_reg != '0);
  assign load_push = head_take && (mem_count_reg == '0) && push;
  assign mem_wr    = push && !load_push;

  function automatic logic [PW-1:0] ptr_inc(logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_ff @(posedge clk) begin
    if (mem_wr) begin
      mem[wr_ptr_reg] <= push_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_reg     <= '0;
      rd_ptr_reg     <= '0;
      mem_count_reg  <= '0;
      count_reg      <= '0;
      head_valid_reg <= 1'b0;
      head_data_reg  <= '0;
    end else begin
      if (mem_wr) begin
        wr_ptr_reg <= ptr_inc(wr_ptr_reg);
      end
      if (load_mem) begin
        head_data_reg  <= mem[rd_ptr_reg];
        rd_ptr_reg     <= ptr_inc(rd_ptr_reg);
        head_valid_reg <= 1'b1;
      end else if (load_push) begin
        head_data_reg  <= push_data;
        head_valid_reg <= 1'b1;
      end else if (pop) begin
        head_valid_reg <= 1'b0;
      end
      mem_count_reg <= mem_count_reg + CNT_W'(mem_wr) - CNT_W'(load_mem);
      count_reg     <= count_reg + CNT_W'(push) - CNT_W'(pop);
    end
  end

  assign head_valid = head_valid_reg;
  assign head_data  = head_data_reg;
  assign count      = count_reg;

  // Credits upstream make both of these unreachable.
  a_no_pop_empty: assert property (@(posedge clk) disable iff (!rst_n)
    !(pop && !head_valid_reg));
  a_no_push_full: assert property (@(posedge clk) disable iff (!rst_n)
    !(push && (count_reg == CNT_W'(DEPTH))));

endmodule

// File: rtl/uop_issue_ctrl.sv
// Issue/collect controller for a fixed-latency, non-stallable uop_block.
// Operands arrive on a valid/ready stream and are registered onto blk_src /
// blk_shamt. A LAT+1 stage valid pipe marks when the block's blk_dst belongs
// to a launched operand; that value is written into a result FIFO. Launches are
// limited by credits (inflight + buffered < DEPTH) so a returning result always
// has a slot. Results leave in issue order on a valid/ready stream.
//
// Optional feature macro: UOP_ISSUE_TAG_EN adds in_tag/out_tag; the tag rides a
// parallel pipe and is stored beside its result.
//
// Ports:
//   clk, rst_n           clock; synchronous active-low reset
//   in_valid/in_ready    operand handshake; in_data, in_shamt (, in_tag)
//   blk_src, blk_shamt   registered operand to the block
//   blk_dst              block result, LAT clocks after blk_src
//   out_valid/out_ready  result handshake; out_data (, out_tag)
//   idle                 nothing in flight and nothing buffered
module uop_issue_ctrl
  import uop_pkg::*;
#(
  parameter int W     = 32,
  parameter int LAT   = 1,
  parameter int DEPTH = 4,
  parameter int TAG_W = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [W-1:0]         in_data,
  input  logic [$clog2(W)-1:0] in_shamt,
`ifdef UOP_ISSUE_TAG_EN
  input  logic [TAG_W-1:0]     in_tag,
  output logic [TAG_W-1:0]     out_tag,
`endif
  output logic [W-1:0]         blk_src,
  output logic [$clog2(W)-1:0] blk_shamt,
  input  logic [W-1:0]         blk_dst,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [W-1:0]         out_data,
  output logic                 idle
);

  localparam int SH_W  = $clog2(W);
  localparam int CNT_W = $clog2(DEPTH + 1);
`ifdef UOP_ISSUE_TAG_EN
  localparam int FW = W + TAG_W;
`else
  localparam int FW = W;
`endif

  if ((DEPTH < 2) || (DEPTH > 16) || (LAT < 0) || (TAG_W < 1)) begin : g_bad_param
    $error("uop_issue_ctrl: parameter out of range");
  end

  logic [W-1:0]     src_reg;
  logic [SH_W-1:0]  shamt_reg;
  logic [LAT:0]     vpipe_reg;
  logic [LAT:0]     vpipe_next;
  logic [CNT_W-1:0] inflight_reg;
  logic [CNT_W-1:0] fifo_count;
  logic [CNT_W:0]   occ;
  logic             accept;
  logic             push;
  logic             pop;
  logic [FW-1:0]    push_word;
  logic [FW-1:0]    head_word;

  // Credits come only from registered counters, so out_ready never reaches
  // in_ready combinationally; a pop returns its credit one cycle later.
  assign occ      = {1'b0, inflight_reg} + {1'b0, fifo_count};
  assign in_ready = rst_n && (occ < (CNT_W + 1)'(DEPTH));
  assign idle     = (occ == '0);
  assign accept   = in_valid && in_ready;
  assign push     = vpipe_reg[LAT];
  assign pop      = out_valid && out_ready;

  // Valid pipe: stage 0 flags the operand now on blk_src; stage LAT flags the
  // matching value on blk_dst.
  assign vpipe_next[0] = accept;
  for (genvar gi = 1; gi <= LAT; gi++) begin : g_vpipe
    assign vpipe_next[gi] = vpipe_reg[gi-1];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      src_reg      <= '0;
      shamt_reg    <= '0;
      vpipe_reg    <= '0;
      inflight_reg <= '0;
    end else begin
      if (accept) begin
        src_reg   <= in_data;
        shamt_reg <= in_shamt;
      end
      vpipe_reg    <= vpipe_next;
      inflight_reg <= inflight_reg + CNT_W'(accept) - CNT_W'(push);
    end
  end

  assign blk_src   = src_reg;
  assign blk_shamt = shamt_reg;

`ifdef UOP_ISSUE_TAG_EN
  // Tag pipe mirrors vpipe: stage 0 is loaded on accept, then shifts each cycle.
  logic [TAG_W-1:0] tpipe_reg [LAT+1];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i <= LAT; i++) begin
        tpipe_reg[i] <= '0;
      end
    end else begin
      if (accept) begin
        tpipe_reg[0] <= in_tag;
      end
      for (int i = 1; i <= LAT; i++) begin
        tpipe_reg[i] <= tpipe_reg[i-1];
      end
    end
  end

  assign push_word = {tpipe_reg[LAT], blk_dst};
  assign out_tag   = head_word[FW-1:W];
`else
  assign push_word = blk_dst;
`endif

  uop_result_fifo #(
    .DW    (FW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .push       (push),
    .push_data  (push_word),
    .pop        (pop),
    .head_valid (out_valid),
    .head_data  (head_word),
    .count      (fifo_count)
  );

  assign out_data = head_word[W-1:0];

endmodule

// File: tb/tb_uop_issue_ctrl.sv
// Bench for uop_issue_ctrl. Four controllers with LAT = 0..3 (DEPTH 4) each
// drive a behavioural block model (dst = src + shamt + 1, LAT register stages).
// A per-instance reference model tracks outstanding results as a queue of
// {value, cycle it becomes visible} and checks handshakes and data every cycle.
module tb_uop_issue_ctrl;

  localparam int NI = 4;
  localparam int DEPTH = 4;

  logic clk;
  int   cyc;
  int   checks;
  int   failures;

  logic [NI-1:0] rst_n;
  logic [NI-1:0] in_valid;
  logic [NI-1:0] in_ready;
  logic [NI-1:0] out_valid;
  logic [NI-1:0] out_ready;
  logic [NI-1:0] idle;
  logic [31:0]   in_data   [NI];
  logic [4:0]    in_shamt  [NI];
  logic [31:0]   blk_src   [NI];
  logic [4:0]    blk_shamt [NI];
  logic [31:0]   blk_dst   [NI];
  logic [31:0]   out_data  [NI];
  logic [3:0]    in_tag    [NI];
`ifdef UOP_ISSUE_TAG_EN
  logic [3:0]    out_tag   [NI];
`endif

  typedef struct {
    logic [31:0] d;
    logic [3:0]  tag;
    int          rdy;
  } exp_t;

  typedef struct {
    bit          rst;
    bit          v;
    logic [31:0] d;
    bit          rdy;
    bit          e_ir;
    bit          e_ov;
    logic [31:0] e_d;
    bit          e_idle;
  } vec_t;

  vec_t tbl [11];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] blk_f(logic [31:0] s, logic [4:0] sh);
    return s + {27'd0, sh} + 32'd1;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, req);
    end
  endtask

  task automatic chk1(input string nm, input logic act, input logic req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0b required=%0b", nm, act, req);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  for (genvar gi = 0; gi < NI; gi++) begin : g_dut
    uop_issue_ctrl #(
      .W     (32),
      .LAT   (gi),
      .DEPTH (DEPTH),
      .TAG_W (4)
    ) u_dut (
      .clk       (clk),
      .rst_n     (rst_n[gi]),
      .in_valid  (in_valid[gi]),
      .in_ready  (in_ready[gi]),
      .in_data   (in_data[gi]),
      .in_shamt  (in_shamt[gi]),
`ifdef UOP_ISSUE_TAG_EN
      .in_tag    (in_tag[gi]),
      .out_tag   (out_tag[gi]),
`endif
      .blk_src   (blk_src[gi]),
      .blk_shamt (blk_shamt[gi]),
      .blk_dst   (blk_dst[gi]),
      .out_valid (out_valid[gi]),
      .out_ready (out_ready[gi]),
      .out_data  (out_data[gi]),
      .idle      (idle[gi])
    );

    // Block model: gi register stages, no reset, no stall.
    if (gi == 0) begin : g_comb
      assign blk_dst[gi] = blk_f(blk_src[gi], blk_shamt[gi]);
    end else begin : g_seq
      logic [31:0] pipe [gi];
      always @(posedge clk) begin
        pipe[0] <= blk_f(blk_src[gi], blk_shamt[gi]);
        for (int k = 1; k < gi; k++) pipe[k] <= pipe[k-1];
      end
      assign blk_dst[gi] = pipe[gi-1];
    end
  end

  // Reference model: a result accepted in cycle c is visible from cycle
  // c+LAT+2 onward, in order, and each outstanding result holds one credit.
  for (genvar gi = 0; gi < NI; gi++) begin : g_mon
    exp_t q[$];
    bit   en;
    int   pop_cnt;
    int   last_pop_cur;
    always @(negedge clk) begin : mon
      int occ;
      bit eov;
      occ = q.size();
      eov = (occ > 0) && (q[0].rdy <= cyc);
      if (en) begin
        chk1($sformatf("in_ready[%0d]", gi), in_ready[gi], rst_n[gi] && (occ < DEPTH));
        chk1($sformatf("out_valid[%0d]", gi), out_valid[gi], eov);
        chk1($sformatf("idle[%0d]", gi), idle[gi], occ == 0);
        if (eov && out_valid[gi]) begin
          chk($sformatf("out_data[%0d]", gi), out_data[gi], q[0].d);
`ifdef UOP_ISSUE_TAG_EN
          chk($sformatf("out_tag[%0d]", gi), 32'(out_tag[gi]), 32'(q[0].tag));
`endif
        end
      end
      if (!rst_n[gi]) begin
        q.delete();
        en = 1'b1;
      end else if (en) begin
        if (out_valid[gi] && out_ready[gi] && (occ > 0)) begin
          $display("txn inst=%0d cyc=%0d pop data=%08h", gi, cyc, out_data[gi]);
          void'(q.pop_front());
          pop_cnt++;
          last_pop_cur = cyc;
        end
        if (in_valid[gi] && in_ready[gi]) begin
          q.push_back('{blk_f(in_data[gi], in_shamt[gi]), in_tag[gi], cyc + gi + 2});
        end
      end
    end
  end

  task automatic drain(input int i);
    int n;
    in_valid[i]  = 1'b0;
    out_ready[i] = 1'b1;
    n = 0;
    while (!idle[i] && (n < 40)) begin
      tick(1);
      n++;
    end
    chk1($sformatf("drain_idle[%0d]", i), idle[i], 1'b1);
    out_ready[i] = 1'b0;
  endtask

  initial begin : main
    int n, acc, p0, start, next_tag;
    bit a;

    rst_n     = '0;
    in_valid  = '0;
    out_ready = '0;
    for (int i = 0; i < NI; i++) begin
      in_data[i]  = '0;
      in_shamt[i] = '0;
      in_tag[i]   = '0;
    end

    //               rst v  d       rdy ir ov e_d     idle
    tbl[0]  = '{1'b1, 1'b1, 32'h10, 1'b0, 1'b1, 1'b0, 32'h0,  1'b1};
    tbl[1]  = '{1'b1, 1'b1, 32'h20, 1'b0, 1'b1, 1'b0, 32'h0,  1'b0};
    tbl[2]  = '{1'b1, 1'b0, 32'h0,  1'b0, 1'b1, 1'b0, 32'h0,  1'b0};
    tbl[3]  = '{1'b1, 1'b0, 32'h0,  1'b0, 1'b1, 1'b1, 32'h11, 1'b0};
    tbl[4]  = '{1'b1, 1'b0, 32'h0,  1'b1, 1'b1, 1'b1, 32'h11, 1'b0};
    tbl[5]  = '{1'b1, 1'b0, 32'h0,  1'b0, 1'b1, 1'b1, 32'h21, 1'b0};
    tbl[6]  = '{1'b1, 1'b0, 32'h0,  1'b0, 1'b1, 1'b1, 32'h21, 1'b0};
    tbl[7]  = '{1'b1, 1'b0, 32'h0,  1'b1, 1'b1, 1'b1, 32'h21, 1'b0};
    tbl[8]  = '{1'b1, 1'b0, 32'h0,  1'b0, 1'b1, 1'b0, 32'h0,  1'b1};
    tbl[9]  = '{1'b0, 1'b1, 32'h55, 1'b0, 1'b0, 1'b0, 32'h0,  1'b1};
    tbl[10] = '{1'b1, 1'b0, 32'h0,  1'b0, 1'b1, 1'b0, 32'h0,  1'b1};

    // Reset held 3 cycles with in_valid high.
    in_valid = '1;
    for (int i = 0; i < NI; i++) in_data[i] = 32'hDEAD_0000 + i;
    tick(3);
    for (int i = 0; i < NI; i++) begin
      chk1($sformatf("rst_in_ready[%0d]", i), in_ready[i], 1'b0);
      chk1($sformatf("rst_out_valid[%0d]", i), out_valid[i], 1'b0);
      chk1($sformatf("rst_idle[%0d]", i), idle[i], 1'b1);
      chk($sformatf("rst_blk_src[%0d]", i), blk_src[i], 32'h0);
      $display("txn reset inst=%0d in_ready=%0b out_valid=%0b idle=%0b", i, in_ready[i], out_valid[i], idle[i]);
    end
    in_valid = '0;
    rst_n    = '1;

    // Table vectors on the LAT=1 instance; expectations hold for the cycle
    // in which the row's inputs are driven.
    for (int r = 0; r < 11; r++) begin
      rst_n[1]     = tbl[r].rst;
      in_valid[1]  = tbl[r].v;
      in_data[1]   = tbl[r].d;
      out_ready[1] = tbl[r].rdy;
      #1;
      chk1($sformatf("tbl%0d_in_ready", r), in_ready[1], tbl[r].e_ir);
      chk1($sformatf("tbl%0d_out_valid", r), out_valid[1], tbl[r].e_ov);
      chk1($sformatf("tbl%0d_idle", r), idle[1], tbl[r].e_idle);
      if (tbl[r].e_ov) chk($sformatf("tbl%0d_out_data", r), out_data[1], tbl[r].e_d);
      $display("txn tbl row=%0d rst_n=%0b v=%0b d=%08h rdy=%0b -> ir=%0b ov=%0b od=%08h idle=%0b",
               r, tbl[r].rst, tbl[r].v, tbl[r].d, tbl[r].rdy, in_ready[1], out_valid[1], out_data[1], idle[1]);
      tick(1);
    end
    in_valid[1] = 1'b0;

    // Single op on LAT=2: accept 0xA5, expect 0xA6 after LAT+1 = 3 edges.
    chk1("single_in_ready", in_ready[2], 1'b1);
    in_valid[2] = 1'b1;
    in_data[2]  = 32'h0000_00A5;
    in_shamt[2] = '0;
    tick(1);
    in_valid[2] = 1'b0;
    n = 0;
    while (!out_valid[2] && (n < 10)) begin
      tick(1);
      n++;
    end
    chk("single_latency", n, 3);
    chk("single_out_data", out_data[2], 32'h0000_00A6);
    $display("txn single lat=%0d data=%08h", n, out_data[2]);
    out_ready[2] = 1'b1;
    tick(1);
    out_ready[2] = 1'b0;
    chk1("single_idle_after_pop", idle[2], 1'b1);
    chk1("single_ov_after_pop", out_valid[2], 1'b0);

    // Stream of 100 back-to-back ops on LAT=1 with out_ready high.
    p0    = g_mon[1].pop_cnt;
    start = cyc;
    acc   = 0;
    out_ready[1] = 1'b1;
    for (int i = 0; i < 100; i++) begin
      in_valid[1] = 1'b1;
      in_data[1]  = i;
      if (!in_ready[1]) acc++;
      tick(1);
    end
    in_valid[1] = 1'b0;
    n = 0;
    while (((g_mon[1].pop_cnt - p0) < 100) && (n < 10)) begin
      tick(1);
      n++;
    end
    chk("stream_ready_low_cycles", acc, 0);
    chk("stream_pops", g_mon[1].pop_cnt - p0, 100);
    chk("stream_last_pop_cycle", g_mon[1].last_pop_cur - start, 102);
    drain(1);

    // Backpressure on LAT=1: exactly DEPTH accepts, credit returns one cycle after a pop.
    out_ready[1] = 1'b0;
    in_valid[1]  = 1'b1;
    acc = 0;
    for (int i = 0; i < 8; i++) begin
      in_data[1] = 32'h100 + acc;
      a = in_ready[1];
      tick(1);
      if (a) acc++;
    end
    chk("bp_accepts", acc, DEPTH);
    chk1("bp_in_ready_full", in_ready[1], 1'b0);
    in_data[1]   = 32'h100 + acc;
    out_ready[1] = 1'b1;
    chk1("bp_in_ready_pulse_cycle", in_ready[1], 1'b0);
    tick(1);
    out_ready[1] = 1'b0;
    chk1("bp_in_ready_after_pulse", in_ready[1], 1'b1);
    $display("txn backpressure accepts=%0d in_ready_after_pulse=%0b", acc, in_ready[1]);
    tick(1);
    drain(1);

    // Reset mid-flight on LAT=3.
    p0 = g_mon[3].pop_cnt;
    in_valid[3] = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_data[3] = 32'h300 + i;
      chk1($sformatf("midrst_accept%0d", i), in_ready[3], 1'b1);
      tick(1);
    end
    in_valid[3] = 1'b0;
    rst_n[3]    = 1'b0;
    out_ready[3] = 1'b1;
    tick(1);
    rst_n[3] = 1'b1;
    acc = 0;
    for (int i = 0; i < 8; i++) begin
      if (out_valid[3]) acc++;
      tick(1);
    end
    chk("midrst_stale_out_valid", acc, 0);
    chk1("midrst_idle", idle[3], 1'b1);
    out_ready[3] = 1'b0;
    in_valid[3]  = 1'b1;
    in_data[3]   = 32'h3A;
    tick(1);
    in_valid[3] = 1'b0;
    n = 0;
    while (!out_valid[3] && (n < 12)) begin
      tick(1);
      n++;
    end
    chk("midrst_next_latency", n, 4);
    chk("midrst_next_data", out_data[3], 32'h3B);
    $display("txn midrst next lat=%0d data=%08h", n, out_data[3]);
    drain(3);
    chk("midrst_pops", g_mon[3].pop_cnt - p0, 1);

`ifdef UOP_ISSUE_TAG_EN
    // Tags 1..8 on LAT=0 with an irregular out_ready pattern.
    begin : tag_test
      bit r_pat [16] = '{0, 1, 0, 0, 1, 1, 0, 1, 0, 0, 0, 1, 1, 0, 1, 1};
      p0 = g_mon[0].pop_cnt;
      next_tag = 1;
      for (int c = 0; c < 60; c++) begin
        out_ready[0] = r_pat[c % 16];
        if (next_tag <= 8) begin
          in_valid[0] = 1'b1;
          in_tag[0]   = 4'(next_tag);
          in_data[0]  = 32'h700 + next_tag;
        end else begin
          in_valid[0] = 1'b0;
        end
        a = in_valid[0] && in_ready[0];
        tick(1);
        if (a) next_tag++;
      end
      drain(0);
      chk("tag_pops", g_mon[0].pop_cnt - p0, 8);
    end
`endif

    // Randomized traffic on all instances, with rare resets.
    for (int c = 0; c < 600; c++) begin
      for (int i = 0; i < NI; i++) begin
        rst_n[i]     = ($urandom_range(0, 99) != 0);
        in_valid[i]  = ($urandom_range(0, 9) < 6);
        out_ready[i] = ($urandom_range(0, 1) == 1);
        in_data[i]   = $urandom;
        in_shamt[i]  = 5'($urandom_range(0, 31));
        in_tag[i]    = 4'($urandom_range(0, 15));
      end
      tick(1);
    end
    rst_n = '1;
    for (int i = 0; i < NI; i++) drain(i);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
